// File: rtl/ctrlpush_if.sv
// Bus bundle between the heap push controller and its environment.
// It carries the push request (start, din), the external size register
// value, the shared heap RAM port (maddr, mdin, mwen, mdout) and the
// status pulses (sizeinc, done, ovf).
// master: the controller side. slave: the environment side.
interface ctrlpush_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);
  logic          start;
  logic [DW-1:0] din;
  logic [AW-1:0] size;
  logic [DW-1:0] mdout;
  logic          sizeinc;
  logic          mwen;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdin;
  logic          done;
  logic          ovf;

  modport master (
    input  start, din, size, mdout,
    output sizeinc, mwen, maddr, mdin, done, ovf
  );

  modport slave (
    output start, din, size, mdout,
    input  sizeinc, mwen, maddr, mdin, done, ovf
  );
endinterface

// File: rtl/ctrlpush.sv
// Push controller for a 1-indexed min-heap held in a shared RAM.
// It latches a key, bumps the external size register, then sifts the key
// up: each larger parent moves down one level until the key's slot is found.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - ctrlpush_if.master: start/din/size/mdout in,
//            sizeinc/mwen/maddr/mdin/done/ovf out
// All bus outputs are combinational decodes of state and registers.
module ctrlpush #(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 8,
  parameter int unsigned MAXSIZE = 255
) (
  input  logic       clk,
  input  logic       reset,
  ctrlpush_if.master bus
);

  localparam logic [AW-1:0] FULL = AW'(MAXSIZE);
  localparam logic [AW-1:0] ROOT = AW'(1);

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    INIT   = 6'b000010,
    PARENT = 6'b000100,
    MOVE   = 6'b001000,
    PLACE  = 6'b010000,
    DONE   = 6'b100000
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [DW-1:0] v, v_n;
  logic [DW-1:0] p, p_n;
  logic          rej, rej_n;

  // State and working registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      v     <= '0;
      p     <= '0;
      rej   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      v     <= v_n;
      p     <= p_n;
      rej   <= rej_n;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    v_n         = v;
    p_n         = p;
    rej_n       = rej;
    bus.sizeinc = 1'b0;
    bus.mwen    = 1'b0;
    bus.maddr   = '0;
    bus.mdin    = '0;
    bus.done    = 1'b0;
    bus.ovf     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.size >= FULL) begin
            // heap full: report rejection without touching RAM or size
            state_n = DONE;
            rej_n   = 1'b1;
          end else begin
            state_n = INIT;
            v_n     = bus.din;
            rej_n   = 1'b0;
          end
        end
      end

      INIT: begin
        // size is still the pre-increment value this cycle
        bus.sizeinc = 1'b1;
        idx_n       = bus.size + ROOT;
        state_n     = PARENT;
      end

      PARENT: begin
        if (idx > ROOT) begin
          bus.maddr = idx >> 1;
          p_n       = bus.mdout;
          // equal keys stop the sift to avoid needless moves
          state_n   = (v < bus.mdout) ? MOVE : PLACE;
        end else begin
          state_n = PLACE;
        end
      end

      MOVE: begin
        bus.mwen  = 1'b1;
        bus.maddr = idx;
        bus.mdin  = p;
        idx_n     = idx >> 1;
        state_n   = PARENT;
      end

      PLACE: begin
        bus.mwen  = 1'b1;
        bus.maddr = idx;
        bus.mdin  = v;
        state_n   = DONE;
      end

      DONE: begin
        bus.done = 1'b1;
        bus.ovf  = rej;
        rej_n    = 1'b0;
        state_n  = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrlpush.sv
// Bench for ctrlpush: behavioural heap RAM and size register around the
// DUT; a reference heap model predicts every sizeinc/write/done event with
// its cycle, and a negedge monitor pops and compares them.
module tb_ctrlpush;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  typedef enum int {EV_INC = 0, EV_WR = 1, EV_DONE = 2} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ovf;
    int            cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  ctrlpush_if #(.DW(DW), .AW(AW)) bus ();

  ctrlpush #(.DW(DW), .AW(AW), .MAXSIZE(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // environment: RAM, size register, cycle counter
  logic [DW-1:0] mem [0:255];
  logic [AW-1:0] size;
  logic [AW-1:0] size_val;
  logic          size_ld;
  logic          mem_clr;
  int            cyc = 0;
  int            inc_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.mwen) begin
      mem[bus.maddr] <= bus.mdin;
    end
    if (size_ld) size <= size_val;
    else if (bus.sizeinc) size <= size + AW'(1);
  end

  assign bus.mdout = mem[bus.maddr];
  assign bus.size  = size;

  // reference model and scoreboard
  logic [DW-1:0] ref_mem [0:255];
  int            ref_size;
  ev_t           exp_q[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input logic [DW-1:0] key, input int t0, output int done_at);
    int i;
    int c;
    if (ref_size >= 255) begin
      exp_q.push_back('{kind: EV_DONE, addr: '0, data: '0, ovf: 1'b1, cyc: t0 + 1});
      done_at = t0 + 1;
      return;
    end
    ref_size++;
    exp_q.push_back('{kind: EV_INC, addr: '0, data: '0, ovf: 1'b0, cyc: t0 + 1});
    i = ref_size;
    c = t0 + 2;
    while (i > 1 && key < ref_mem[i / 2]) begin
      exp_q.push_back('{kind: EV_WR, addr: AW'(i), data: ref_mem[i / 2], ovf: 1'b0, cyc: c + 1});
      ref_mem[i] = ref_mem[i / 2];
      i = i / 2;
      c += 2;
    end
    ref_mem[i] = key;
    exp_q.push_back('{kind: EV_WR, addr: AW'(i), data: key, ovf: 1'b0, cyc: c + 1});
    exp_q.push_back('{kind: EV_DONE, addr: '0, data: '0, ovf: 1'b0, cyc: c + 2});
    done_at = c + 2;
  endtask

  // monitor: every sizeinc/write/done must match the next predicted event
  always @(negedge clk) begin : mon
    ev_t      e;
    ev_kind_t k;
    if (reset) begin
      if (bus.sizeinc) inc_cnt++;
      if (!bus.done) chk("ovf_without_done", 32'(bus.ovf), 32'd0);
      if (bus.sizeinc || bus.mwen || bus.done) begin
        k = bus.sizeinc ? EV_INC : (bus.mwen ? EV_WR : EV_DONE);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'(k), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", 32'(k), 32'(e.kind));
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          if (e.kind == EV_WR) begin
            chk("wr_addr", 32'(bus.maddr), 32'(e.addr));
            chk("wr_data", 32'(bus.mdin), 32'(e.data));
          end
          if (e.kind == EV_DONE) chk("done_ovf", 32'(bus.ovf), 32'(e.ovf));
        end
      end
    end
  end

  function automatic logic [31:0] outs();
    return 32'({bus.sizeinc, bus.mwen, bus.maddr, bus.mdin, bus.done, bus.ovf});
  endfunction

  task automatic reinit();
    @(negedge clk);
    mem_clr  = 1'b1;
    size_ld  = 1'b1;
    size_val = '0;
    @(posedge clk);
    #1;
    mem_clr = 1'b0;
    size_ld = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    ref_size = 0;
  endtask

  task automatic start_push(input logic [DW-1:0] key, output int t0, output int done_at);
    @(negedge clk);
    t0        = cyc;
    bus.start = 1'b1;
    bus.din   = key;
    expect_push(key, t0, done_at);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.din   = DW'($urandom);
  endtask

  task automatic push(input logic [DW-1:0] key);
    int t0;
    int done_at;
    start_push(key, t0, done_at);
    repeat (done_at - t0) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i <= ref_size; i++) chk("heap_slot", 32'(mem[i]), 32'(ref_mem[i]));
    chk("size_reg", 32'(size), 32'(ref_size));
  endtask

  initial begin
    int t0;
    int d1;
    int d2;
    int inc0;
    bit hit;

    bus.start = 1'b0;
    bus.din   = '0;
    mem_clr   = 1'b1;
    size_ld   = 1'b1;
    size_val  = '0;
    ref_size  = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // reset state
    @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    size_ld = 1'b0;
    reset   = 1'b1;

    // single push into empty heap
    inc0 = inc_cnt;
    push(8'd5);
    chk("single_inc", 32'(inc_cnt - inc0), 32'd1);

    // two-level sift: heap {3,7,9} then push 1
    reinit();
    push(8'd3);
    push(8'd7);
    push(8'd9);
    push(8'd1);

    // equal key stops at first compare
    reinit();
    push(8'd4);
    push(8'd4);

    // full heap: rejected, no write, no sizeinc
    reinit();
    @(negedge clk);
    size_ld  = 1'b1;
    size_val = 8'd255;
    @(posedge clk);
    #1;
    size_ld  = 1'b0;
    ref_size = 255;
    inc0 = inc_cnt;
    start_push(8'd8, t0, d1);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_drain", 32'(exp_q.size()), 32'd0);
    chk("ovf_no_inc", 32'(inc_cnt - inc0), 32'd0);
    chk("ovf_size_kept", 32'(size), 32'd255);

    // reset asserted during MOVE
    reinit();
    push(8'd5);
    start_push(8'd1, t0, d1);
    hit = 1'b0;
    for (int n = 0; n < 10 && !hit; n++) begin
      @(posedge clk);
      #1;
      if (bus.mwen) hit = 1'b1;
    end
    chk("reached_move", 32'(hit), 32'd1);
    chk("move_addr", 32'(bus.maddr), 32'd2);
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 32'd0);
    @(posedge clk);
    #1;
    chk("held_reset_outputs", outs(), 32'd0);
    reinit();
    @(negedge clk);
    reset = 1'b1;
    inc0 = inc_cnt;
    push(8'd2);
    chk("post_reset_inc", 32'(inc_cnt - inc0), 32'd1);

    // start held high across two pushes
    reinit();
    inc0 = inc_cnt;
    @(negedge clk);
    t0        = cyc;
    bus.start = 1'b1;
    bus.din   = 8'd6;
    expect_push(8'd6, t0, d1);
    @(posedge clk);
    #1;
    bus.din = 8'd2;
    expect_push(8'd2, d1 + 1, d2);
    repeat (d2 - t0) @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("held_drain", 32'(exp_q.size()), 32'd0);
    chk("held_inc_pulses", 32'(inc_cnt - inc0), 32'd2);
    chk("held_root", 32'(mem[1]), 32'd2);
    chk("held_child", 32'(mem[2]), 32'd6);

    // random keys
    reinit();
    for (int n = 0; n < 10; n++) push(DW'($urandom_range(0, 255)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
